// File: rtl/flash_rd_arbiter.sv
// rtl/flash_rd_arbiter.sv - two-port round-robin read scheduler for the shared flash read engine
//
// Shares one flash read engine between the instruction-fetch port and the data
// port. One engine read is sequenced per buffer miss; repeat reads of the last
// fetched word are answered from a one-entry word buffer.
//
// Ports:
//   HCLK, HRESETn          clock, synchronous active-low reset
//   flush                  invalidate the word buffer
//   i_req/i_addr           instruction-port request (held until i_ack)
//   i_ack/i_rdata          instruction-port one-cycle ack, data held to next ack
//   d_req/d_addr           data-port request (held until d_ack)
//   d_ack/d_rdata          data-port one-cycle ack, data held to next ack
//   eng_start/eng_addr     engine start pulse and word address
//   eng_busy               engine cannot accept a start
//   eng_done/eng_data      engine completion pulse and read word
//   grant                  current engine owner, one-hot {data, instr}

module flash_rd_arbiter #(
    parameter int AW = 24
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          flush,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [31:0]   i_rdata,
    input  logic          d_req,
    input  logic [AW-1:0] d_addr,
    output logic          d_ack,
    output logic [31:0]   d_rdata,
    output logic          eng_start,
    output logic [AW-1:0] eng_addr,
    input  logic          eng_busy,
    input  logic          eng_done,
    input  logic [31:0]   eng_data,
    output logic [1:0]    grant
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic            r_i_ack,      w_i_ack_nxt;
    logic            r_d_ack,      w_d_ack_nxt;
    logic            r_eng_start,  w_eng_start_nxt;
    logic [31:0]     r_i_rdata,    w_i_rdata_nxt;
    logic [31:0]     r_d_rdata,    w_d_rdata_nxt;
    logic [AW-1:0]   r_eng_addr,   w_eng_addr_nxt;
    logic [1:0]      r_grant,      w_grant_nxt;
    logic            r_buf_valid,  w_buf_valid_nxt;
    logic [AW-3:0]   r_buf_addr,   w_buf_addr_nxt;
    logic [31:0]     r_buf_data,   w_buf_data_nxt;
    logic            r_last_d,     w_last_d_nxt;   // 1: data port was served last
    logic            r_sel_d,      w_sel_d_nxt;    // port owning the current access

    logic            w_any_req;
    logic            w_sel_i;
    logic [AW-3:0]   w_sel_waddr;
    logic            w_hit;
    logic            w_unused_addr_bits;

    // Byte-lane bits never take part in word selection.
    assign w_unused_addr_bits = &{1'b0, i_addr[1:0], d_addr[1:0]};

    assign w_any_req   = i_req | d_req;
    // Instruction port wins when alone, or when the data port was served last.
    assign w_sel_i     = i_req & (~d_req | r_last_d);
    assign w_sel_waddr = w_sel_i ? i_addr[AW-1:2] : d_addr[AW-1:2];
    // A flush in the same cycle must not be bypassed by a hit.
    assign w_hit       = r_buf_valid & ~flush & (w_sel_waddr == r_buf_addr);

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_state     <= S_IDLE;
            r_i_ack     <= 1'b0;
            r_d_ack     <= 1'b0;
            r_eng_start <= 1'b0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
            r_eng_addr  <= '0;
            r_grant     <= 2'b00;
            r_buf_valid <= 1'b0;
            r_buf_addr  <= '0;
            r_buf_data  <= '0;
            r_last_d    <= 1'b1;
            r_sel_d     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_i_ack     <= w_i_ack_nxt;
            r_d_ack     <= w_d_ack_nxt;
            r_eng_start <= w_eng_start_nxt;
            r_i_rdata   <= w_i_rdata_nxt;
            r_d_rdata   <= w_d_rdata_nxt;
            r_eng_addr  <= w_eng_addr_nxt;
            r_grant     <= w_grant_nxt;
            r_buf_valid <= w_buf_valid_nxt;
            r_buf_addr  <= w_buf_addr_nxt;
            r_buf_data  <= w_buf_data_nxt;
            r_last_d    <= w_last_d_nxt;
            r_sel_d     <= w_sel_d_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_i_ack_nxt     = 1'b0;
        w_d_ack_nxt     = 1'b0;
        w_eng_start_nxt = 1'b0;
        w_i_rdata_nxt   = r_i_rdata;
        w_d_rdata_nxt   = r_d_rdata;
        w_eng_addr_nxt  = r_eng_addr;
        w_grant_nxt     = r_grant;
        w_buf_valid_nxt = r_buf_valid;
        w_buf_addr_nxt  = r_buf_addr;
        w_buf_data_nxt  = r_buf_data;
        w_last_d_nxt    = r_last_d;
        w_sel_d_nxt     = r_sel_d;

        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_sel_d_nxt = ~w_sel_i;
                    if (w_hit) begin
                        // Ack is registered, so it appears in RESP.
                        w_state_nxt = S_RESP;
                        if (w_sel_i) begin
                            w_i_ack_nxt   = 1'b1;
                            w_i_rdata_nxt = r_buf_data;
                        end else begin
                            w_d_ack_nxt   = 1'b1;
                            w_d_rdata_nxt = r_buf_data;
                        end
                    end else if (!eng_busy) begin
                        w_state_nxt     = S_ISSUE;
                        w_eng_start_nxt = 1'b1;
                        w_eng_addr_nxt  = {w_sel_waddr, 2'b00};
                        w_grant_nxt     = w_sel_i ? 2'b01 : 2'b10;
                    end
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (eng_done) begin
                    w_state_nxt     = S_RESP;
                    w_buf_data_nxt  = eng_data;
                    w_buf_addr_nxt  = r_eng_addr[AW-1:2];
                    w_buf_valid_nxt = ~flush;
                    if (r_sel_d) begin
                        w_d_ack_nxt   = 1'b1;
                        w_d_rdata_nxt = eng_data;
                    end else begin
                        w_i_ack_nxt   = 1'b1;
                        w_i_rdata_nxt = eng_data;
                    end
                end
            end
            S_RESP: begin
                w_state_nxt  = S_IDLE;
                w_last_d_nxt = r_sel_d;
                w_grant_nxt  = 2'b00;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (flush) begin
            w_buf_valid_nxt = 1'b0;
        end
    end

    assign i_ack     = r_i_ack;
    assign d_ack     = r_d_ack;
    assign i_rdata   = r_i_rdata;
    assign d_rdata   = r_d_rdata;
    assign eng_start = r_eng_start;
    assign eng_addr  = r_eng_addr;
    assign grant     = r_grant;

endmodule

// File: tb/tb_flash_rd_arbiter.sv
// tb/tb_flash_rd_arbiter.sv - randomized self-checking bench for flash_rd_arbiter

module tb_flash_rd_arbiter;

    localparam int AW = 24;

    logic          HCLK;
    logic          HRESETn;
    logic          flush;
    logic          i_req, d_req;
    logic [AW-1:0] i_addr, d_addr;
    logic          i_ack, d_ack;
    logic [31:0]   i_rdata, d_rdata;
    logic          eng_start;
    logic [AW-1:0] eng_addr;
    logic          eng_busy;
    logic          eng_done;
    logic [31:0]   eng_data;
    logic [1:0]    grant;

    logic          flush_main;
    logic          flush_eng;
    assign flush = flush_main | flush_eng;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int eng_delay = 1;
    bit flush_on_done = 1'b0;
    int done_cyc = -100;

    // Transaction-level model: buffered word and who was served last.
    bit            m_valid;
    logic [AW-3:0] m_waddr;
    bit            m_last_d;

    flash_rd_arbiter #(.AW(AW)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .flush     (flush),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ack     (i_ack),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_addr    (d_addr),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .eng_start (eng_start),
        .eng_addr  (eng_addr),
        .eng_busy  (eng_busy),
        .eng_done  (eng_done),
        .eng_data  (eng_data),
        .grant     (grant)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    always @(posedge HCLK) cyc <= cyc + 1;

    function automatic logic [31:0] word_data(input logic [AW-1:0] a);
        logic [AW-1:0] w;
        w = {a[AW-1:2], 2'b00};
        if (w == 24'h000100) return 32'hDEADBEEF;
        if (w == 24'h000040) return 32'h12345678;
        return {8'h5A, w} ^ 32'h13579BDF;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Flash engine: done arrives eng_delay cycles after the start pulse.
    initial begin
        int cnt;
        logic [AW-1:0] a;
        cnt = 0;
        a = '0;
        eng_done = 1'b0;
        eng_data = '0;
        flush_eng = 1'b0;
        forever begin
            @(negedge HCLK);
            eng_done  = 1'b0;
            flush_eng = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    eng_done = 1'b1;
                    eng_data = word_data(a);
                    done_cyc = cyc;
                    if (flush_on_done) flush_eng = 1'b1;
                end
            end
            if (eng_start) begin
                a = eng_addr;
                cnt = eng_delay;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_i_ack"},     32'(i_ack),     32'd0);
        check_eq({tag, "_d_ack"},     32'(d_ack),     32'd0);
        check_eq({tag, "_eng_start"}, 32'(eng_start), 32'd0);
        check_eq({tag, "_grant"},     32'(grant),     32'd0);
        check_eq({tag, "_i_rdata"},   i_rdata,        32'd0);
        check_eq({tag, "_d_rdata"},   d_rdata,        32'd0);
        check_eq({tag, "_eng_addr"},  32'(eng_addr),  32'd0);
    endtask

    task automatic model_reset();
        m_valid  = 1'b0;
        m_waddr  = '0;
        m_last_d = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge HCLK);
        HRESETn = 1'b0;
        @(negedge HCLK);
        HRESETn = 1'b1;
        model_reset();
    endtask

    // One request set (one or both ports) carried to completion.
    task automatic run_txn(input bit use_i, input bit use_d,
                           input logic [AW-1:0] ai, input logic [AW-1:0] ad,
                           input int dly, input int busy_cyc);
        bit            srv_d[2];
        bit            srv_hit[2];
        logic [AW-1:0] exp_saddr[2];
        logic [1:0]    exp_grant[2];
        int            n_srv, n_miss, n_ack, n_start, rel;
        bit            first_d, p;
        logic [AW-1:0] a;

        if (use_i && use_d) first_d = ~m_last_d;
        else                first_d = use_d;
        n_srv  = int'(use_i) + int'(use_d);
        n_miss = 0;
        for (int s = 0; s < n_srv; s++) begin
            p = (s == 0) ? first_d : ~first_d;
            a = p ? ad : ai;
            srv_d[s]   = p;
            srv_hit[s] = m_valid && (m_waddr == a[AW-1:2]);
            if (!srv_hit[s]) begin
                exp_saddr[n_miss] = {a[AW-1:2], 2'b00};
                exp_grant[n_miss] = p ? 2'b10 : 2'b01;
                n_miss++;
                m_valid = 1'b1;
                m_waddr = a[AW-1:2];
            end
            m_last_d = p;
        end
        if (srv_hit[0]) rel = (busy_cyc + 1 > 3) ? busy_cyc + 1 : 3;
        else            rel = busy_cyc + 1;

        @(negedge HCLK);
        eng_delay = dly;
        i_req  = use_i;
        i_addr = ai;
        d_req  = use_d;
        d_addr = ad;
        eng_busy = (busy_cyc > 0);
        n_ack   = 0;
        n_start = 0;
        for (int k = 1; k <= 80 && n_ack < n_srv; k++) begin
            @(negedge HCLK);
            if (k == busy_cyc) eng_busy = 1'b0;
            if (eng_start) begin
                if (n_start < n_miss) begin
                    check_eq("start_addr", 32'(eng_addr), 32'(exp_saddr[n_start]));
                    check_eq("start_grant", 32'(grant), 32'(exp_grant[n_start]));
                    if (n_start == 0) check_eq("start_latency", 32'(k), 32'(rel));
                end
                n_start++;
            end
            if (i_ack || d_ack) begin
                check_eq("ack_onehot", 32'(i_ack & d_ack), 32'd0);
                p = d_ack;
                check_eq("ack_order", 32'(p), 32'(srv_d[n_ack]));
                if (p) check_eq("d_rdata", d_rdata, word_data(ad));
                else   check_eq("i_rdata", i_rdata, word_data(ai));
                if (srv_hit[n_ack]) begin
                    if (n_ack == 0) check_eq("hit_latency", 32'(k), 32'd1);
                end else begin
                    check_eq("miss_ack_after_done", 32'(cyc), 32'(done_cyc + 1));
                end
                if (p) d_req = 1'b0;
                else   i_req = 1'b0;
                n_ack++;
            end
        end
        check_eq("acks_seen", 32'(n_ack), 32'(n_srv));
        check_eq("start_count", 32'(n_start), 32'(n_miss));
        eng_busy = 1'b0;
        i_req = 1'b0;
        d_req = 1'b0;
    endtask

    function automatic logic [AW-1:0] pick_addr();
        logic [AW-1:0] b;
        case ($urandom_range(0, 3))
            0:       b = 24'h000100;
            1:       b = 24'h000104;
            2:       b = 24'h000200;
            default: b = 24'hFFFFFC;
        endcase
        return b | AW'($urandom_range(0, 3));
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sel;
        bit ui, ud, acc;
        HRESETn = 1'b0;
        flush_main = 1'b0;
        i_req = 1'b0;
        d_req = 1'b0;
        i_addr = '0;
        d_addr = '0;
        eng_busy = 1'b0;
        model_reset();
        repeat (3) @(negedge HCLK);
        check_reset_outputs("reset");
        HRESETn = 1'b1;

        // Cold miss then buffer hits from both ports.
        run_txn(1, 0, 24'h000102, '0, 5, 0);
        run_txn(1, 0, 24'h000100, '0, 5, 0);
        run_txn(0, 1, '0, 24'h000103, 5, 0);

        // Contention from reset, twice.
        do_reset();
        run_txn(1, 1, 24'h000010, 24'h000020, 3, 0);
        run_txn(1, 1, 24'h000030, 24'h000050, 2, 0);

        // Flush coincident with eng_done.
        flush_on_done = 1'b1;
        run_txn(1, 0, 24'h000040, '0, 4, 0);
        flush_on_done = 1'b0;
        m_valid = 1'b0;
        run_txn(1, 0, 24'h000040, '0, 2, 0);

        // Data port hits while instruction miss waits on a busy engine.
        run_txn(1, 1, 24'h000080, 24'h000040, 2, 4);

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            sel = $urandom_range(0, 2);
            ui = (sel != 1);
            ud = (sel != 0);
            if ($urandom_range(0, 7) == 0) begin
                @(negedge HCLK);
                flush_main = 1'b1;
                @(negedge HCLK);
                flush_main = 1'b0;
                m_valid = 1'b0;
            end
            run_txn(ui, ud, pick_addr(), pick_addr(), $urandom_range(1, 5), $urandom_range(0, 3));
        end

        // Reset while an engine read is in flight.
        run_txn(1, 0, 24'h000200, '0, 2, 0);
        @(negedge HCLK);
        eng_delay = 6;
        i_req = 1'b1;
        i_addr = 24'h000204;
        @(negedge HCLK);
        check_eq("midwait_start", 32'(eng_start), 32'd1);
        @(negedge HCLK);
        HRESETn = 1'b0;
        i_req = 1'b0;
        @(negedge HCLK);
        check_reset_outputs("midwait");
        HRESETn = 1'b1;
        model_reset();
        acc = 1'b0;
        repeat (8) begin
            @(negedge HCLK);
            acc = acc | i_ack | d_ack | eng_start;
        end
        check_eq("stray_done_ignored", 32'(acc), 32'd0);
        run_txn(1, 0, 24'h000200, '0, 2, 0);
        run_txn(1, 0, 24'h000204, '0, 2, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
